// File: rtl/g2_table_updater.sv
// g2_table_updater
// Inserts and deletes srcIP keys in a hash table built from singly linked chains.
// A chain starts at cmd_index. Overflow entries are taken one after another from
// FREE_BASE up to TABLE_ENTRY_SIZE, and they are never given back.
//
// Entry layout: [59:49] next (0 = end of chain), [48:38] ruleID, [37:33] zero,
//               [32] valid, [31:0] srcIP.
//
// Ports:
//   clk, rst_n           single clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while IDLE
//   cmd_op               0 = insert, 1 = delete
//   cmd_index            chain head address
//   cmd_key              srcIP key
//   cmd_ruleID           rule ID, used by insert only
//   rd_addr / rd_data    table read port; data arrives one cycle after the address
//   we / wr_addr / din   table write port; one strobe per write state
//   done / status        1-cycle completion pulse; 00 OK, 01 DUP, 10 FULL, 11 NOT_FOUND
//
// state   | meaning
// IDLE    | waiting for a command (cmd_ready high)
// RD      | present rd_addr = cur
// WAIT    | capture rd_data into the entry register
// EVAL    | decide: finish, follow next, or write
// WR_NEW  | write new/updated entry (allocated slot, reused slot, or cleared valid)
// WR_LINK | rewrite chain tail with next = allocated slot
// DONE    | pulse done with status
module g2_table_updater #(
    parameter int TABLE_ENTRY_SIZE = 18,
    parameter int INDEX_BIT_LEN    = 11,
    parameter int ENTRY_DATA_WIDTH = 60,
    parameter int FREE_BASE        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [INDEX_BIT_LEN-1:0]    cmd_index,
    input  logic [31:0]                 cmd_key,
    input  logic [INDEX_BIT_LEN-1:0]    cmd_ruleID,
    output logic [INDEX_BIT_LEN-1:0]    rd_addr,
    input  logic [ENTRY_DATA_WIDTH-1:0] rd_data,
    output logic                        we,
    output logic [INDEX_BIT_LEN-1:0]    wr_addr,
    output logic [ENTRY_DATA_WIDTH-1:0] din,
    output logic                        done,
    output logic [1:0]                  status
);

    localparam int NEXT_LSB  = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
    localparam int RULE_LSB  = NEXT_LSB - INDEX_BIT_LEN;
    localparam int ZERO_W    = RULE_LSB - 33;
    localparam int VALID_BIT = 32;

    localparam logic [INDEX_BIT_LEN-1:0] L_TABLE_MAX = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
    localparam logic [INDEX_BIT_LEN-1:0] L_WALK_MAX  = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE + 1);
    localparam logic [INDEX_BIT_LEN-1:0] L_FREE_BASE = INDEX_BIT_LEN'(FREE_BASE);

    localparam logic [1:0] STAT_OK   = 2'b00;
    localparam logic [1:0] STAT_DUP  = 2'b01;
    localparam logic [1:0] STAT_FULL = 2'b10;
    localparam logic [1:0] STAT_NF   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_EVAL, S_WR_NEW, S_WR_LINK, S_DONE
    } state_t;

    state_t                      r_state;
    logic                        r_rst_done;
    logic                        r_op;
    logic [31:0]                 r_key;
    logic [INDEX_BIT_LEN-1:0]    r_rule;
    logic [INDEX_BIT_LEN-1:0]    r_cur;
    logic [ENTRY_DATA_WIDTH-1:0] r_entry;
    logic [INDEX_BIT_LEN-1:0]    r_walk;
    logic [INDEX_BIT_LEN-1:0]    r_free_ptr;
    logic [INDEX_BIT_LEN-1:0]    r_wr_addr;
    logic [ENTRY_DATA_WIDTH-1:0] r_wr_data;
    logic                        r_alloc;
    logic [1:0]                  r_status;

    state_t                      w_state_nxt;
    logic [INDEX_BIT_LEN-1:0]    w_cur_nxt;
    logic                        w_load_wr;
    logic [INDEX_BIT_LEN-1:0]    w_wr_addr_nxt;
    logic [ENTRY_DATA_WIDTH-1:0] w_wr_data_nxt;
    logic                        w_alloc_nxt;
    logic                        w_set_status;
    logic [1:0]                  w_status_nxt;

    logic [INDEX_BIT_LEN-1:0]    w_e_next;
    logic                        w_e_valid;
    logic [31:0]                 w_e_ip;
    logic                        w_hit;
    logic [INDEX_BIT_LEN-1:0]    w_walk_inc;
    logic                        w_guard;
    logic                        w_accept;

    assign w_e_next   = r_entry[ENTRY_DATA_WIDTH-1:NEXT_LSB];
    assign w_e_valid  = r_entry[VALID_BIT];
    assign w_e_ip     = r_entry[31:0];
    assign w_hit      = w_e_valid && (w_e_ip == r_key);
    assign w_walk_inc = r_walk + 1'b1;
    // Counts this EVAL too, so a chain that loops back on itself stops on its 20th visit.
    assign w_guard    = (w_walk_inc > L_WALK_MAX);
    assign w_accept   = cmd_valid && cmd_ready;
    assign status     = r_status;

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_load_wr     = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_alloc_nxt   = 1'b0;
        w_set_status  = 1'b0;
        w_status_nxt  = r_status;
        cmd_ready     = 1'b0;
        rd_addr       = '0;
        we            = 1'b0;
        wr_addr       = '0;
        din           = '0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = r_rst_done;
                if (cmd_valid && r_rst_done) w_state_nxt = S_RD;
            end
            S_RD: begin
                rd_addr     = r_cur;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: w_state_nxt = S_EVAL;
            S_EVAL: begin
                w_set_status = 1'b1;
                w_status_nxt = STAT_OK;
                if (w_guard) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = r_op ? STAT_NF : STAT_FULL;
                end else if (w_hit) begin
                    if (!r_op) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = STAT_DUP;
                    end else begin
                        w_state_nxt   = S_WR_NEW;
                        w_load_wr     = 1'b1;
                        w_wr_addr_nxt = r_cur;
                        w_wr_data_nxt = {r_entry[ENTRY_DATA_WIDTH-1:VALID_BIT+1], 1'b0, r_entry[31:0]};
                    end
                end else if (!r_op && !w_e_valid) begin
                    // Reusing an invalid slot in place keeps the rest of the chain behind it.
                    w_state_nxt   = S_WR_NEW;
                    w_load_wr     = 1'b1;
                    w_wr_addr_nxt = r_cur;
                    w_wr_data_nxt = {w_e_next, r_rule, {ZERO_W{1'b0}}, 1'b1, r_key};
                end else if (w_e_next != '0) begin
                    w_set_status = 1'b0;
                    w_cur_nxt    = w_e_next;
                    w_state_nxt  = S_RD;
                end else if (r_op) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_NF;
                end else if (r_free_ptr > L_TABLE_MAX) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = STAT_FULL;
                end else begin
                    w_state_nxt   = S_WR_NEW;
                    w_load_wr     = 1'b1;
                    w_alloc_nxt   = 1'b1;
                    w_wr_addr_nxt = r_free_ptr;
                    w_wr_data_nxt = {{INDEX_BIT_LEN{1'b0}}, r_rule, {ZERO_W{1'b0}}, 1'b1, r_key};
                end
            end
            S_WR_NEW: begin
                // Gating with rst_n keeps a write in the reset cycle away from the table.
                we          = rst_n;
                wr_addr     = r_wr_addr;
                din         = r_wr_data;
                w_state_nxt = r_alloc ? S_WR_LINK : S_DONE;
            end
            S_WR_LINK: begin
                // r_wr_addr still holds the slot that was just allocated.
                we          = rst_n;
                wr_addr     = r_cur;
                din         = {r_wr_addr, r_entry[NEXT_LSB-1:0]};
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rst_done <= 1'b0;
            r_op       <= 1'b0;
            r_key      <= '0;
            r_rule     <= '0;
            r_cur      <= '0;
            r_entry    <= '0;
            r_walk     <= '0;
            r_free_ptr <= L_FREE_BASE;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_alloc    <= 1'b0;
            r_status   <= STAT_OK;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_key  <= cmd_key;
                        r_rule <= cmd_ruleID;
                        r_cur  <= cmd_index;
                        r_walk <= '0;
                    end
                end
                S_WAIT: r_entry <= rd_data;
                S_EVAL: begin
                    r_walk <= w_walk_inc;
                    r_cur  <= w_cur_nxt;
                    if (w_load_wr) begin
                        r_wr_addr <= w_wr_addr_nxt;
                        r_wr_data <= w_wr_data_nxt;
                        r_alloc   <= w_alloc_nxt;
                    end
                    if (w_set_status) r_status <= w_status_nxt;
                end
                S_WR_NEW: begin
                    if (r_alloc) r_free_ptr <= r_free_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_g2_table_updater.sv
module tb_g2_table_updater;
    localparam int TES = 18;
    localparam int FB  = 16;
    localparam int IW  = 11;
    localparam int DW  = 60;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [IW-1:0] cmd_index;
    logic [31:0]   cmd_key;
    logic [IW-1:0] cmd_ruleID;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          we;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] din;
    logic          done;
    logic [1:0]    status;

    always #5 clk = ~clk;

    g2_table_updater #(
        .TABLE_ENTRY_SIZE(TES),
        .INDEX_BIT_LEN(IW),
        .ENTRY_DATA_WIDTH(DW),
        .FREE_BASE(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_key(cmd_key), .cmd_ruleID(cmd_ruleID),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .din(din),
        .done(done), .status(status)
    );

    // Table RAM: synchronous read, one-cycle latency
    logic [DW-1:0] mem [0:2047];
    logic          mem_clr = 1'b0;
    logic          pl_en   = 1'b0;
    logic [IW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            cyc     = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= mem[rd_addr];
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (we) mem[wr_addr] <= din;
    end

    int            wq_a[$];
    logic [DW-1:0] wq_d[$];
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wq_a.push_back(int'(wr_addr));
            wq_d.push_back(din);
        end
    end

    // Reference model: plain table of fields plus allocation pointer
    bit            m_valid [0:TES];
    int            m_next  [0:TES];
    logic [IW-1:0] m_rule  [0:TES];
    logic [31:0]   m_ip    [0:TES];
    int            m_free;
    int            exp_a[$];
    logic [DW-1:0] exp_d[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int a);
        return {IW'(m_next[a]), m_rule[a], 5'd0, m_valid[a], m_ip[a]};
    endfunction

    task automatic mwrite(input int a);
        exp_a.push_back(a);
        exp_d.push_back(pack(a));
    endtask

    task automatic model_cmd(input bit op, input int idx, input logic [31:0] key,
                             input logic [IW-1:0] rule, output logic [1:0] st, output int lat);
        int cur, reads, slot;
        bit fin;
        exp_a.delete();
        exp_d.delete();
        cur = idx; reads = 0; fin = 0; st = 2'd0;
        while (!fin) begin
            reads++;
            if (reads > TES + 1) begin
                st = op ? 2'd3 : 2'd2; fin = 1;
            end else if (m_valid[cur] && m_ip[cur] == key) begin
                if (!op) st = 2'd1;
                else begin m_valid[cur] = 0; mwrite(cur); st = 2'd0; end
                fin = 1;
            end else if (!op && !m_valid[cur]) begin
                m_valid[cur] = 1; m_rule[cur] = rule; m_ip[cur] = key;
                mwrite(cur); st = 2'd0; fin = 1;
            end else if (m_next[cur] != 0) begin
                cur = m_next[cur];
            end else if (op) begin
                st = 2'd3; fin = 1;
            end else if (m_free > TES) begin
                st = 2'd2; fin = 1;
            end else begin
                slot = m_free; m_free++;
                m_valid[slot] = 1; m_next[slot] = 0; m_rule[slot] = rule; m_ip[slot] = key;
                mwrite(slot);
                m_next[cur] = slot;
                mwrite(cur);
                st = 2'd0; fin = 1;
            end
        end
        lat = 3 * reads + 1 + exp_a.size();
    endtask

    task automatic run_cmd(input bit op, input int idx, input logic [31:0] key,
                           input logic [IW-1:0] rule, output logic [1:0] st, output int lat);
        int t0, n;
        bit seen;
        wq_a.delete();
        wq_d.delete();
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_index = IW'(idx); cmd_key = key; cmd_ruleID = rule;
        t0 = cyc;
        @(negedge clk);
        // keep a different request pending while busy; it must be ignored
        chk("ready_busy", cmd_ready, 0);
        cmd_op = ~op; cmd_index = 11'd1; cmd_key = 32'hDEAD0000; cmd_ruleID = '1;
        @(negedge clk);
        cmd_valid = 0;
        n = 0; seen = 0;
        while (n < 200) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
            n++;
        end
        chk("done_seen", seen, 1);
        lat = cyc - t0;
        st  = status;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic cmd_check(input string tag, input bit op, input int idx, input logic [31:0] key,
                             input logic [IW-1:0] rule, output logic [1:0] gs, output int gl);
        logic [1:0] es;
        int el;
        model_cmd(op, idx, key, rule, es, el);
        run_cmd(op, idx, key, rule, gs, gl);
        chk({tag, "_status"}, gs, es);
        chk({tag, "_latency"}, gl, el);
        chk({tag, "_nwrites"}, wq_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < wq_a.size()) begin
                chk({tag, "_wr_addr"}, wq_a[i], exp_a[i]);
                chk({tag, "_din"}, wq_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic clear_all();
        @(negedge clk);
        mem_clr = 1;
        @(negedge clk);
        mem_clr = 0;
        for (int i = 0; i <= TES; i++) begin
            m_valid[i] = 0; m_next[i] = 0; m_rule[i] = '0; m_ip[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        m_free = FB;
    endtask

    task automatic mem_compare(input string tag);
        for (int a = 0; a <= TES; a++) chk(tag, mem[a], pack(a));
    endtask

    initial begin
        logic [1:0]    gs;
        int            gl, n;
        bit            seen, op;
        int            idx;
        logic [31:0]   key;
        logic [IW-1:0] rule;
        logic [DW-1:0] exp_word;

        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_index = '0; cmd_key = '0; cmd_ruleID = '0;
        m_free = FB;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_din", din, 0);
        rst_n = 1;
        #1 chk("ready_same_cycle", cmd_ready, 0);
        @(negedge clk);
        chk("ready_rise", cmd_ready, 1);
        clear_all();

        // first insert into empty head
        cmd_check("ins1", 0, 3, 32'h0A000001, 11'd5, gs, gl);
        exp_word = {11'd0, 11'd5, 5'd0, 1'b1, 32'h0A000001};
        chk("ins1_lat_const", gl, 5);
        chk("ins1_st_const", gs, 2'b00);
        if (wq_d.size() > 0) chk("ins1_din_const", wq_d[0], exp_word);
        cmd_check("dup", 0, 3, 32'h0A000001, 11'd7, gs, gl);
        chk("dup_st_const", gs, 2'b01);
        cmd_check("ins2", 0, 3, 32'h0A000002, 11'd6, gs, gl);
        if (wq_a.size() == 2) begin
            chk("ins2_alloc_const", wq_a[0], 16);
            exp_word = {11'd16, 11'd5, 5'd0, 1'b1, 32'h0A000001};
            chk("ins2_link_const", wq_d[1], exp_word);
        end
        cmd_check("del1", 1, 3, 32'h0A000002, 11'd0, gs, gl);
        chk("del1_lat_const", gl, 8);
        cmd_check("del_nf", 1, 3, 32'h0BADBEEF, 11'd0, gs, gl);
        chk("del_nf_st_const", gs, 2'b11);

        // fill the overflow area, then one more allocation must fail
        cmd_check("fill_a", 0, 5, 32'h0C000001, 11'd1, gs, gl);
        cmd_check("fill_b", 0, 5, 32'h0C000002, 11'd2, gs, gl);
        cmd_check("fill_c", 0, 5, 32'h0C000003, 11'd3, gs, gl);
        cmd_check("full", 0, 5, 32'h0C000004, 11'd4, gs, gl);
        chk("full_st_const", gs, 2'b10);
        chk("full_lat_const", gl, 10);

        // self-looping entry
        m_valid[7] = 1; m_next[7] = 7; m_rule[7] = 11'd1; m_ip[7] = 32'h00001234;
        @(negedge clk);
        pl_en = 1; pl_addr = 11'd7; pl_data = pack(7);
        @(negedge clk);
        pl_en = 0;
        cmd_check("loop_ins", 0, 7, 32'h00000099, 11'd9, gs, gl);
        chk("loop_ins_lat_const", gl, 61);
        cmd_check("loop_del", 1, 7, 32'h00000099, 11'd0, gs, gl);
        chk("loop_del_st_const", gs, 2'b11);
        mem_compare("mem_directed");

        // reset in the middle of an allocation write
        do_reset();
        clear_all();
        cmd_check("r_a", 0, 3, 32'h0A000001, 11'd5, gs, gl);
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1; cmd_op = 0; cmd_index = 11'd3; cmd_key = 32'h0A000002; cmd_ruleID = 11'd6;
        @(negedge clk);
        cmd_valid = 0;
        seen = 0; n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (we) begin seen = 1; break; end
            n++;
        end
        chk("r_we_seen", seen, 1);
        chk("r_we_addr", wr_addr, 16);
        #1 rst_n = 0;
        #1 chk("r_we_gated", we, 0);
        @(negedge clk);
        chk("r_we_after", we, 0);
        chk("r_done_after", done, 0);
        chk("r_ready_in_rst", cmd_ready, 0);
        rst_n = 1;
        @(negedge clk);
        chk("r_ready_rise", cmd_ready, 1);
        m_free = FB;
        mem_compare("r_mem");
        cmd_check("r_b", 0, 3, 32'h0A000002, 11'd6, gs, gl);
        if (wq_a.size() > 0) chk("r_free_base", wq_a[0], 16);

        // randomized episodes
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            clear_all();
            for (int c = 0; c < 10; c++) begin
                op   = ($urandom_range(0, 3) == 0);
                idx  = int'($urandom_range(0, TES));
                key  = 32'hC0A80000 | 32'($urandom_range(0, 5));
                rule = IW'($urandom_range(0, 2047));
                cmd_check("rnd", op, idx, key, rule, gs, gl);
            end
            mem_compare("rnd_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/g2_table_updater.md
G2_TABLE_UPDATER -- requirements
Module: g2_table_updater

Interface
REQ-001 Parameters SHALL be, one per line:
- TABLE_ENTRY_SIZE, 18, highest table address; the table holds entries 0..TABLE_ENTRY_SIZE.
- INDEX_BIT_LEN, 11, index/ruleID width.
- ENTRY_DATA_WIDTH, 60, entry width.
- FREE_BASE, 16, first overflow slot; FREE_BASE SHALL be >= 1.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_op  in  1  0=insert, 1=delete.
- cmd_index  in  INDEX_BIT_LEN  chain head address.
- cmd_key  in  32  srcIP key.
- cmd_ruleID  in  INDEX_BIT_LEN  rule ID, used by insert only.
- rd_addr  out  INDEX_BIT_LEN  table read address.
- rd_data  in  ENTRY_DATA_WIDTH  read data, valid 1 cycle after rd_addr.
- we  out  1  table write strobe.
- wr_addr  out  INDEX_BIT_LEN  write address.
- din  out  ENTRY_DATA_WIDTH  write data.
- done  out  1  1-cycle completion pulse.
- status  out  2  00=OK, 01=DUP, 10=FULL, 11=NOT_FOUND; valid while done=1.
REQ-003 Entry format SHALL be:
- [59:49] next index; 0 = end of chain.
- [48:38] ruleID.
- [37:33] zero.
- [32] valid.
- [31:0] srcIP.

Function
REQ-004 A command SHALL be accepted in a cycle where cmd_valid=1 and cmd_ready=1; cmd_op, cmd_index, cmd_key and cmd_ruleID SHALL be latched in that cycle.
REQ-005 cmd_ready SHALL be 1 only in IDLE.
REQ-006 FSM states SHALL be IDLE, RD, WAIT, EVAL, WR_NEW, WR_LINK, DONE.
REQ-007 Walk transitions:
- IDLE->RD on accept, with cur=cmd_index.
- RD drives rd_addr=cur, then goes to WAIT.
- WAIT captures rd_data, then goes to EVAL.
REQ-008 Insert decisions in EVAL, in priority order:
- valid=1 and srcIP=key -> DONE, status DUP, no write.
- valid=0 -> WR_NEW at cur, keeping that entry's next field.
- next!=0 -> RD with cur=next.
- next=0 -> allocate free_ptr; if free_ptr>TABLE_ENTRY_SIZE -> DONE, FULL, no write; else WR_NEW at free_ptr with next=0, then WR_LINK.
REQ-009 WR_LINK SHALL rewrite the tail entry at cur with its next field set to the allocated slot and all other fields unchanged, then go to DONE with status OK.
REQ-010 free_ptr SHALL increment by 1 in the WR_NEW cycle of an allocation only, and slots SHALL never be reclaimed.
REQ-011 Delete decisions in EVAL:
- valid=1 and srcIP=key -> write entry at cur with valid=0 and all other bits unchanged, then DONE, OK.
- else next!=0 -> RD with cur=next.
- else -> DONE, NOT_FOUND, no write.
REQ-012 Loop guard: the walk counter SHALL be cleared on accept and incremented per EVAL; when it exceeds TABLE_ENTRY_SIZE+1, insert SHALL end FULL and delete SHALL end NOT_FOUND, with no write.
REQ-013 we SHALL be 1 for exactly one cycle per write state, and din and wr_addr SHALL be valid only in that cycle.
REQ-014 Each command SHALL perform at most two writes.
REQ-015 Latency from accept to done SHALL be 3k+1 cycles for k chain reads, plus 1 per write.
REQ-016 done SHALL pulse for 1 cycle in DONE; DONE->IDLE SHALL be unconditional.
REQ-017 cmd_valid asserted while busy SHALL be ignored and not queued.

Reset
REQ-018 When rst_n=0 at posedge, the block SHALL:
- go to IDLE;
- set free_ptr=FREE_BASE;
- clear the walk counter;
- drive we=0, done=0, status=00, rd_addr=0, wr_addr=0, din=0, cmd_ready=0.
REQ-019 cmd_ready SHALL rise the cycle after rst_n=1.
REQ-020 Reset mid-command SHALL abort the command with no further writes; a write in flight in the reset cycle SHALL be suppressed.

Verification
REQ-021 Insert key 0x0A000001, rule 5, index 3 into empty table -> one write: addr 3, din {11'd0, 11'd5, 5'd0, 1'b1, 0x0A000001}; done with OK after 5 cycles.
REQ-022 Repeat the REQ-021 insert with rule 7 -> no write; status DUP.
REQ-023 Insert key 0x0A000002, rule 6, index 3 (head valid, next=0) -> write addr 16 {0, 6, 1, key}, then write addr 3 with next=16; free_ptr=17; status OK.
REQ-024 Delete key 0x0A000002 at index 3 -> two reads; write addr 16 with valid=0; OK. Delete 0x0BADBEEF -> NOT_FOUND, no write.
REQ-025 Allocate until free_ptr=19; the next allocating insert -> FULL, no write. Self-loop entry (next=own index) -> walk aborts after 20 EVALs.
REQ-026 rst_n=0 during WR_NEW -> we=0 next cycle; free_ptr=16; then cmd_ready=1.
